// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and response layout for the ALU issue front end
// Purpose: constants and types imported by alu_issue_ctrl.
// Contents: DATA_W, OP_W, TAG_W defaults, ALU opcode constants,
//           response record {data, z, tag} and a width helper.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 2;
    localparam int TAG_W  = 2;

    localparam logic [1:0] ALU_NOP = 2'd0;
    localparam logic [1:0] ALU_OP1 = 2'd1;
    localparam logic [1:0] ALU_OP2 = 2'd2;
    localparam logic [1:0] ALU_OP3 = 2'd3;

    // Field widths of one buffered response: {data, z, tag}.
    localparam int RSP_Z_W = 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              z;
        logic [TAG_W-1:0]  tag;
    } alu_rsp_t;

    // Packed width of a response for non-default data/tag widths.
    function automatic int rsp_width(input int data_w, input int tag_w);
        return data_w + RSP_Z_W + tag_w;
    endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// rtl/rsp_fifo2.sv - 2-entry in-order synchronous FIFO with occupancy count
// Purpose: buffers completed ALU responses until the consumer takes them.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_push, i_data     write strobe and entry (ignored when full without a pop)
//   i_pop              read strobe (ignored when empty)
//   o_data             head entry, stable until popped
//   o_count            number of stored entries (0..2)
module rsp_fifo2 #(
    parameter int W = 19
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = i_pop && (o_count != 2'd0);
    // A full buffer can still accept when the head leaves on the same edge.
    assign do_push = i_push && ((o_count != 2'd2) || do_pop);
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            o_count <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + 2'd1;
                2'b01:   o_count <= o_count - 2'd1;
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - requester-side issue controller for a registered ALU
// Purpose: accepts one operation at a time, drives and holds the ALU ports,
//          waits ALU_LAT edges, captures result/zero flag and returns them
//          with the request tag through a 2-entry response buffer.
// Ports:
//   i_clk, i_rst                         clock, asynchronous active-high reset
//   i_req_* / o_req_ready                request channel (valid/ready)
//   o_alu_in1, o_alu_in2, o_alu_op       ALU operand/opcode drive
//   i_alu_out, i_alu_z                   ALU result and zero flag
//   o_rsp_* / i_rsp_ready                response channel (valid/ready)
//   o_busy                               operation in flight or response buffered
module alu_issue_ctrl #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int OP_W    = alu_pkg::OP_W,
    parameter int TAG_W   = alu_pkg::TAG_W,
    parameter int ALU_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [DATA_W-1:0] i_req_in1,
    input  logic [DATA_W-1:0] i_req_in2,
    input  logic [OP_W-1:0]   i_req_op,
    input  logic [TAG_W-1:0]  i_req_tag,
    output logic [DATA_W-1:0] o_alu_in1,
    output logic [DATA_W-1:0] o_alu_in2,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic              i_alu_z,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_z,
    output logic [TAG_W-1:0]  o_rsp_tag,
    output logic              o_busy
);
    import alu_pkg::*;

    localparam int RSP_W = rsp_width(DATA_W, TAG_W);
    localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [TAG_W-1:0]  tag_q;
    logic              accept;
    logic              push;
    logic [1:0]        fifo_count;
    logic [RSP_W-1:0]  rsp_head;

    // Ready depends only on registered state; held low while reset is asserted.
    assign o_req_ready = !i_rst && (state == S_IDLE) && (fifo_count != 2'd2);
    assign accept      = i_req_valid && o_req_ready;
    assign o_busy      = (state != S_IDLE) || (fifo_count != 2'd0);
    assign o_rsp_valid = (fifo_count != 2'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_WAIT;
                    cnt_next   = CNT_W'(ALU_LAT);
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    // Result is valid on this edge; admission guaranteed a free slot.
                    push       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operands hold their last values in IDLE; only the opcode drops to NOP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_alu_in1 <= '0;
            o_alu_in2 <= '0;
            o_alu_op  <= '0;
            tag_q     <= '0;
        end else if (accept) begin
            o_alu_in1 <= i_req_in1;
            o_alu_in2 <= i_req_in2;
            o_alu_op  <= i_req_op;
            tag_q     <= i_req_tag;
        end else if (push) begin
            o_alu_op  <= OP_W'(ALU_NOP);
        end
    end

    rsp_fifo2 #(
        .W (RSP_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  ({i_alu_out, i_alu_z, tag_q}),
        .i_pop   (i_rsp_ready && o_rsp_valid),
        .o_data  (rsp_head),
        .o_count (fifo_count)
    );

    assign o_rsp_data = rsp_head[RSP_W-1 -: DATA_W];
    assign o_rsp_z    = rsp_head[TAG_W];
    assign o_rsp_tag  = rsp_head[TAG_W-1:0];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    int          n_chk  = 0;
    int          n_fail = 0;

    // Latency-1 instance
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_z, busy, alu_z;
    logic [15:0] req_in1, req_in2, alu_in1, alu_in2, alu_out, rsp_data;
    logic [1:0]  req_op, req_tag, alu_op, rsp_tag;

    // Latency-0 instance
    logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_z0, busy0, alu_z0;
    logic [15:0] req_in10, req_in20, alu_in10, alu_in20, alu_out0, rsp_data0;
    logic [1:0]  req_op0, req_tag0, alu_op0, rsp_tag0;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd1:    return a + b;
            2'd2:    return a - b;
            2'd3:    return a * b;
            default: return 16'd0;
        endcase
    endfunction

    always_ff @(posedge clk) alu_out <= alu_f(alu_op, alu_in1, alu_in2);
    assign alu_z    = (alu_out == 16'd0);
    assign alu_out0 = alu_f(alu_op0, alu_in10, alu_in20);
    assign alu_z0   = (alu_out0 == 16'd0);

    alu_issue_ctrl #(.DATA_W(16), .OP_W(2), .TAG_W(2), .ALU_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_in1(req_in1), .i_req_in2(req_in2), .i_req_op(req_op), .i_req_tag(req_tag),
        .o_alu_in1(alu_in1), .o_alu_in2(alu_in2), .o_alu_op(alu_op),
        .i_alu_out(alu_out), .i_alu_z(alu_z),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_z(rsp_z), .o_rsp_tag(rsp_tag),
        .o_busy(busy)
    );

    alu_issue_ctrl #(.DATA_W(16), .OP_W(2), .TAG_W(2), .ALU_LAT(0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0),
        .i_req_in1(req_in10), .i_req_in2(req_in20), .i_req_op(req_op0), .i_req_tag(req_tag0),
        .o_alu_in1(alu_in10), .o_alu_in2(alu_in20), .o_alu_op(alu_op0),
        .i_alu_out(alu_out0), .i_alu_z(alu_z0),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0),
        .o_rsp_data(rsp_data0), .o_rsp_z(rsp_z0), .o_rsp_tag(rsp_tag0),
        .o_busy(busy0)
    );

    // A capture into a full buffer without a simultaneous pop must never happen.
    always @(negedge clk) begin
        if (!rst && dut.u_fifo.i_push && dut.u_fifo.o_count == 2'd2 && !dut.u_fifo.i_pop) begin
            n_fail++;
            $error("FAIL fifo_push_full: push=1 count=2 expected no push");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [1:0] tag);
        int k = 0;
        while (!req_ready && k < 20) begin
            tick();
            k++;
        end
        chk("issue_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_in1 = a; req_in2 = b; req_tag = tag;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_in1 = 0; req_in2 = 0; req_op = 0; req_tag = 0; rsp_ready = 0;
        req_valid0 = 0; req_in10 = 0; req_in20 = 0; req_op0 = 0; req_tag0 = 0; rsp_ready0 = 0;
        tick(); tick();

        // Reset state
        chk("rst_req_ready", {31'd0, req_ready}, 0);
        chk("rst_alu_op",    {30'd0, alu_op},    0);
        chk("rst_alu_in1",   {16'd0, alu_in1},   0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_busy",      {31'd0, busy},      0);
        rst = 1'b0;
        tick();
        chk("idle_req_ready", {31'd0, req_ready}, 1);

        // Single op: 20 + 5
        issue(2'd1, 16'd20, 16'd5, 2'd1);
        chk("single_alu_op",  {30'd0, alu_op},    1);
        chk("single_alu_in1", {16'd0, alu_in1},   20);
        chk("single_alu_in2", {16'd0, alu_in2},   5);
        chk("single_ready_wait", {31'd0, req_ready}, 0);
        chk("single_busy",    {31'd0, busy},      1);
        chk("single_no_rsp_n1", {31'd0, rsp_valid}, 0);
        tick();
        chk("single_ready_wait2", {31'd0, req_ready}, 0);
        chk("single_no_rsp_n2", {31'd0, rsp_valid}, 0);
        tick();
        chk("single_rsp_valid", {31'd0, rsp_valid}, 1);
        chk("single_rsp_data",  {16'd0, rsp_data},  25);
        chk("single_rsp_z",     {31'd0, rsp_z},     0);
        chk("single_rsp_tag",   {30'd0, rsp_tag},   1);
        chk("single_alu_nop",   {30'd0, alu_op},    0);
        chk("single_ready_idle", {31'd0, req_ready}, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single_drained", {31'd0, rsp_valid}, 0);
        chk("single_not_busy", {31'd0, busy},    0);

        // Zero flag: 10 - 10
        issue(2'd2, 16'd10, 16'd10, 2'd2);
        tick(); tick();
        chk("zero_data", {16'd0, rsp_data}, 0);
        chk("zero_z",    {31'd0, rsp_z},    1);
        chk("zero_tag",  {30'd0, rsp_tag},  2);
        chk("zero_alu_nop", {30'd0, alu_op}, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: two responses held, buffer full
        issue(2'd2, 16'd12, 16'd24, 2'd3);
        tick(); tick();
        issue(2'd3, 16'd3, 16'd25, 2'd0);
        tick(); tick();
        chk("bp_full_ready", {31'd0, req_ready}, 0);
        chk("bp_head_data",  {16'd0, rsp_data},  32'hFFF4);
        chk("bp_head_tag",   {30'd0, rsp_tag},   3);
        chk("bp_busy",       {31'd0, busy},      1);
        // Request held while not ready is not consumed
        req_valid = 1'b1; req_op = 2'd1; req_in1 = 16'd7; req_in2 = 16'd7; req_tag = 2'd1;
        tick(); tick();
        chk("bp_hold_alu_op",  {30'd0, alu_op},   0);
        chk("bp_hold_alu_in1", {16'd0, alu_in1},  3);
        chk("bp_head_stable",  {16'd0, rsp_data}, 32'hFFF4);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_second_data", {16'd0, rsp_data}, 75);
        chk("bp_second_tag",  {30'd0, rsp_tag},  0);
        chk("bp_second_valid", {31'd0, rsp_valid}, 1);
        tick();
        chk("bp_empty", {31'd0, rsp_valid}, 0);
        rsp_ready = 1'b0;

        // Simultaneous push and pop with one entry buffered
        issue(2'd1, 16'd1, 16'd2, 2'd1);
        tick(); tick();
        chk("pp_head_first", {16'd0, rsp_data}, 3);
        issue(2'd1, 16'd4, 16'd4, 2'd2);
        tick();
        rsp_ready = 1'b1;
        tick();
        chk("pp_count",     {30'd0, dut.u_fifo.o_count}, 1);
        chk("pp_head_data", {16'd0, rsp_data}, 8);
        chk("pp_head_tag",  {30'd0, rsp_tag},  2);
        tick();
        chk("pp_drained", {31'd0, rsp_valid}, 0);
        rsp_ready = 1'b0;

        // Reset in the middle of an operation
        issue(2'd1, 16'd23, 16'd25, 2'd1);
        chk("rm_alu_in1_pre", {16'd0, alu_in1}, 23);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_alu_in1",  {16'd0, alu_in1},  0);
        chk("rm_alu_in2",  {16'd0, alu_in2},  0);
        chk("rm_alu_op",   {30'd0, alu_op},   0);
        chk("rm_busy",     {31'd0, busy},     0);
        chk("rm_ready",    {31'd0, req_ready}, 0);
        chk("rm_rsp_valid", {31'd0, rsp_valid}, 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rm_no_rsp", {31'd0, rsp_valid}, 0);
        issue(2'd1, 16'd23, 16'd25, 2'd2);
        tick(); tick();
        chk("rm_retry_data", {16'd0, rsp_data}, 48);
        chk("rm_retry_tag",  {30'd0, rsp_tag},  2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Latency-0 instance: response after N+1
        req_valid0 = 1'b1; req_op0 = 2'd1; req_in10 = 16'd20; req_in20 = 16'd5; req_tag0 = 2'd3;
        chk("l0_ready", {31'd0, req_ready0}, 1);
        tick();
        req_valid0 = 1'b0;
        chk("l0_no_rsp_n", {31'd0, rsp_valid0}, 0);
        chk("l0_alu_op",   {30'd0, alu_op0},    1);
        tick();
        chk("l0_rsp_valid", {31'd0, rsp_valid0}, 1);
        chk("l0_rsp_data",  {16'd0, rsp_data0},  25);
        chk("l0_rsp_tag",   {30'd0, rsp_tag0},   3);
        chk("l0_alu_nop",   {30'd0, alu_op0},    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
